data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data-memory controller for the MIPS MEM stage.
//  - Byte/half/word loads and stores, little-endian lanes.
//  - Load sign/zero extension and alignment/range error detection.
//  - Configurable read latency via a valid/ready request and response handshake.
//  - Post-reset hardware clear sweep; core stalls while req_ready=0.
// PARAMETERS
//  DATA_W        32   data width (multiple of 8; lane logic sized for 32)
//  ADDR_W        32   byte-address width
//  DEPTH         256  number of DATA_W words
//  RD_LAT        1    cycles from request accept to resp_valid (>=1)
//  CLEAR_ON_RST  1    1: zero all words after reset; 0: contents kept
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when valid&ready at clk edge
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       size_e: 00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in  1       load zero-extends (lbu/lhu) when 1
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data; low bytes used for byte/half
//  resp_valid  out  1       one-cycle response pulse
//  resp_data   out  DATA_W  extended load data; 0 for stores and errors
//  resp_err    out  1       misaligned, out-of-range or illegal size
//  clearing    out  1       high during the post-reset clear sweep
// BEHAVIOUR
//  Reset values
//   - rst=1: state=CLEAR if CLEAR_ON_RST, else IDLE.
//   - req_ready=0, resp_valid=0, resp_data=0, resp_err=0.
//   - clearing=CLEAR_ON_RST; clear index=0.
//  Reset mid-operation
//   - An in-flight response is dropped.
//   - A write already accepted stays committed.
//  CLEAR
//   - Writes 0 to word idx each cycle, idx 0..DEPTH-1 (DEPTH cycles).
//   - Then moves to IDLE and drops clearing.
//   - Requests are ignored during CLEAR.
//  Addressing
//   - Word index = req_addr[ADDR_W-1:2]; byte lane = req_addr[1:0].
//   - Error if any of: half with addr[0]=1; word with addr[1:0]!=0; size=11; index>=DEPTH.
//  Accept (valid&ready)
//   - Store without error: only the enabled byte lanes of the word are written at this edge.
//   - Error: memory is untouched.
//   - Load: the word is read at this edge; lane shift and extension are registered.
//   - Then state=BUSY, cnt=RD_LAT-1.
//  BUSY
//   - cnt decrements each cycle.
//   - resp_valid=1 when cnt==0, carrying that request's data/err (err forces data 0).
//   - Response comes exactly RD_LAT cycles after acceptance.
//  Ready
//   - req_ready = (IDLE) | (BUSY & cnt==0), so back-to-back requests run at 1 per RD_LAT cycles.
//   - On a back-to-back edge: a new accept goes to BUSY, otherwise to IDLE.
//  Store-then-load to the same word on consecutive accepts returns the new data.
//  Store lane packing
//   - Byte: wdata[7:0] replicated to all lanes; byte-enable = 1<<addr[1:0].
//   - Half: wdata[15:0] replicated to both halves; byte-enable = 0011 or 1100.
//  Load extension: bit 7 (byte) / bit 15 (half) of the selected lane, unless req_unsigned.
// STRUCTURE
//  - Package mem_pkg:
//    - size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD)
//    - state_e (CLEAR, IDLE, BUSY)
//    - localparam LANES = DATA_W/8
//  - Sub-module mem_lane_align (combinational):
//    - Store path: size/addr -> byte-enable and replicated wdata.
//    - Load path: word/size/lane/unsigned -> extended data, plus the error flag.
//  - Top: FSM, latency counter, clear index, storage array, response registers.
// TESTING
//  1. Reset with CLEAR_ON_RST=1, DEPTH=256 -> clearing high exactly 256 cycles, then req_ready=1;
//     lw of addr 0x3FC returns 0.
//  2. sw 0xDEADBEEF @0x10; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE;
//     lh @0x10 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000DEAD.
//  3. sb 0x5A @0x21 over word 0x11223344 -> lw @0x20 returns 0x11225A44.
//  4. RD_LAT=3: lw accepted at cycle t -> resp_valid only at t+3, req_ready=0 at t+1..t+2;
//     a second lw accepted at t+3 responds at t+6.
//  5. lh @0x02 ok; lw @0x06, lh @0x05, size=11, lw @0x400 (DEPTH=256) -> resp_err=1, resp_data=0,
//     and a following lw shows memory unchanged.
//  6. Assert rst during BUSY -> no resp_valid; after clear, word previously stored reads 0.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and lane geometry for the MEM-stage data-memory controller.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } state_e;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data memory (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  size_e             req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              clearing;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err, clearing
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err, clearing
  );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Little-endian lane steering: store byte-enables/replication, load extraction/extension, error flag.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  size_e             size,
  input  logic [ADDR_W-1:0] addr,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              err
);
  logic [1:0]        lane;
  logic [ADDR_W-3:0] word_idx;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign lane     = addr[1:0];
  assign word_idx = addr[ADDR_W-1:2];
  assign rbyte    = rword[8*lane +: 8];
  assign rhalf    = rword[16*lane[1] +: 16];

  assign err = (size == SZ_BAD)
             | ((size == SZ_HALF) & lane[0])
             | ((size == SZ_WORD) & (lane != 2'b00))
             | (word_idx >= (ADDR_W-2)'(DEPTH));

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = '0;
    unique case (size)
      SZ_BYTE: begin
        be        = LANES'(1) << lane;
        wdata_rep = {LANES{wdata[7:0]}};
        rdata_ext = {{(DATA_W-8){rbyte[7] & ~is_unsigned}}, rbyte};
      end
      SZ_HALF: begin
        be        = {{2{lane[1]}}, {2{~lane[1]}}};
        wdata_rep = {(LANES/2){wdata[15:0]}};
        rdata_ext = {{(DATA_W-16){rhalf[15] & ~is_unsigned}}, rhalf};
      end
      SZ_WORD: begin
        be        = '1;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// MIPS MEM-stage data memory: post-reset clear sweep, lane-steered stores, fixed-latency loads.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] rword;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;
  logic              err;

  assign accept  = bus.req_valid & bus.req_ready;
  assign acc_idx = bus.req_addr[IDX_W+1:2];
  assign rword   = mem[acc_idx];

  mem_lane_align #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_align (
    .size        (bus.req_size),
    .addr        (bus.req_addr),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .err         (err)
  );

  // NOTE: the storage array is deliberately not reset; the CLEAR sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && bus.req_we && !err) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[acc_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
      cnt            <= '0;
      clr_idx        <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      bus.clearing   <= (CLEAR_ON_RST != 0);
    end else begin
      bus.resp_valid <= 1'b0;
      unique case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH-1)) begin
            state         <= IDLE;
            bus.clearing  <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        IDLE, BUSY: begin
          if (accept) begin
            state          <= BUSY;
            cnt            <= CNT_W'(RD_LAT-1);
            bus.resp_valid <= (RD_LAT == 1);
            bus.req_ready  <= (RD_LAT == 1);
            bus.resp_data  <= (bus.req_we || err) ? '0 : rdata_ext;
            bus.resp_err   <= err;
          end else if (state == BUSY && cnt != '0) begin
            // ready and the response pulse both land on the cycle the count reaches zero
            cnt            <= cnt - 1'b1;
            bus.resp_valid <= (cnt == CNT_W'(1));
            bus.req_ready  <= (cnt == CNT_W'(1));
          end else begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
